// File: rtl/meas_seq.sv
// meas_seq: conversion sequencer for the comparator-based timing front end.
// Pulses afe_reset, times discharge-release to trigger rising edge, averages
// 2^AVG_LOG2 samples and presents the result on a valid/ready port.
// Build option: define TRIG_SYNC_EN to pass trigger through a 2-flop
// synchronizer (adds 2 cycles to every recorded count); undefined feeds
// trigger straight into the edge detector.
module meas_seq #(
  parameter int CNT_W        = 8,
  parameter int DISCH_CYCLES = 4,
  parameter int TIMEOUT      = 250,
  parameter int AVG_LOG2     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             trigger,
  output logic             afe_reset,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result,
  output logic             timeout_flag
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam int DW    = (DISCH_CYCLES > 1) ? $clog2(DISCH_CYCLES) : 1;
  localparam logic [DW-1:0]    DISCH_LAST = DW'(DISCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, DISCH, MEASURE, DONE} state_t;

  state_t             state, state_n;
  logic [DW-1:0]      disch_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx;
  logic               trig_s;
  logic               trig_q;
  logic               rise;
  logic               sample_hit;
  logic               last_sample;
  logic               tmo;
  logic               begin_conv;

  // Truncating average: drop the AVG_LOG2 fractional bits of the sum.
  function automatic logic [CNT_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] shifted;
    shifted = a >> AVG_LOG2;
    return shifted[CNT_W-1:0];
  endfunction

`ifdef TRIG_SYNC_EN
  logic trig_meta_p0;
  logic trig_sync_p1;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_meta_p0 <= 1'b0;
      trig_sync_p1 <= 1'b0;
    end else begin
      trig_meta_p0 <= trigger;
      trig_sync_p1 <= trig_meta_p0;
    end
  end

  assign trig_s = trig_sync_p1;
`else
  // Direct path keeps the analog-digital-analog loop free of extra latency.
  assign trig_s = trigger;
`endif

  // Edge register: remembers the previous trig_s so only a 0->1 counts.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_s;
  end

  assign rise        = trig_s & ~trig_q;
  assign acc_sum     = acc + ACC_W'(cnt);
  assign sample_hit  = (state == MEASURE) && rise;
  assign last_sample = (idx == IDX_LAST);
  // A rise in the final timeout cycle still records the sample.
  assign tmo         = (state == MEASURE) && !rise && (cnt == CNT_LAST);
  assign begin_conv  = ((state == IDLE) && (start || continuous)) ||
                       ((state == DONE) && result_ready && continuous);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_n      = state;
    afe_reset    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || continuous) state_n = DISCH;
      end
      DISCH: begin
        afe_reset = 1'b1;
        if (disch_cnt == DISCH_LAST) state_n = MEASURE;
      end
      MEASURE: begin
        if (rise)                  state_n = last_sample ? DONE : DISCH;
        else if (cnt == CNT_LAST)  state_n = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_n = continuous ? DISCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pulse/interval counters, accumulator and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      disch_cnt    <= '0;
      cnt          <= '0;
      acc          <= '0;
      idx          <= '0;
      result       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == DISCH) disch_cnt <= (disch_cnt == DISCH_LAST) ? '0 : disch_cnt + DW'(1);
      else                disch_cnt <= '0;

      if (state == MEASURE) cnt <= cnt + CNT_W'(1);
      else                  cnt <= '0;

      if (begin_conv) begin
        acc          <= '0;
        idx          <= '0;
        timeout_flag <= 1'b0;
      end else if (sample_hit) begin
        acc <= acc_sum;
        idx <= idx + IDX_W'(1);
        if (last_sample) result <= avg_trunc(acc_sum);
      end else if (tmo) begin
        result       <= '1;
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule
